la_trg_seq: RTL and testbench

Multi-stage sequential trigger for the logic-analyzer acquisition path. It watches an AXI4-stream of digital samples and passes the stream through unchanged. The trigger fires only after a programmable sequence of up to SN pattern/edge conditions has matched, each a programmable number of times, in order. It is the generalised successor of the single-condition comparator/edge trigger and feeds the acquisition controller's trigger input.

---
 rtl/la_trg_seq.sv | 162 ++++++++++++++++
 tb/tb_la_trg_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_trg_seq.sv
// Multi-stage sequential trigger: walks up to SN pattern/edge conditions in order over an
// AXI4-stream of samples, pulsing sts_trg when the last active stage completes.
module la_trg_seq #(
  parameter  int DW = 8,
  parameter  int SN = 4,
  parameter  int CW = 16,
  localparam int NW = $clog2(SN + 1),
  localparam int SW = (SN > 1) ? $clog2(SN) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ctl_rst,
  input  logic             ctl_arm,
  input  logic [NW-1:0]    cfg_num,
  input  logic [SN*DW-1:0] cfg_msk,
  input  logic [SN*DW-1:0] cfg_val,
  input  logic [SN*DW-1:0] cfg_pos,
  input  logic [SN*DW-1:0] cfg_neg,
  input  logic [SN*CW-1:0] cfg_cnt,
  output logic             sts_arm,
  output logic [SW-1:0]    sts_stg,
  output logic             sts_trg,
  output logic             sts_done,
  input  logic [DW-1:0]    sti_tdata,
  input  logic             sti_tlast,
  input  logic             sti_tvalid,
  output logic             sti_tready,
  output logic [DW-1:0]    sto_tdata,
  output logic             sto_tlast,
  output logic             sto_tvalid,
  input  logic             sto_tready
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_e;

  state_e        state_q;
  logic [SW-1:0] stg_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] prv_q;
  logic          pvl_q;
  logic          trg_q;
  logic          arm_q;
  logic          done_q;

  logic          xfer;
  logic [DW-1:0] cur_msk;
  logic [DW-1:0] cur_val;
  logic [DW-1:0] cur_pos;
  logic [DW-1:0] cur_neg;
  logic [CW-1:0] cur_cnt;
  logic [DW-1:0] pos;
  logic [DW-1:0] neg;
  logic          cmp;
  logic          edg;
  logic          hit;
  logic [NW-1:0] num_eff;
  logic          at_last;
  logic [CW:0]   need;
  logic [CW:0]   cnt_d;
  logic          reached;
  logic [SW-1:0] stg_d;

  assign sto_tdata  = sti_tdata;
  assign sto_tlast  = sti_tlast;
  assign sto_tvalid = sti_tvalid;
  assign sti_tready = sto_tready;
  assign xfer       = sti_tvalid & sto_tready;

  assign sts_arm  = arm_q;
  assign sts_stg  = stg_q;
  assign sts_trg  = trg_q;
  assign sts_done = done_q;

  always_comb begin
    cur_msk = '0;
    cur_val = '0;
    cur_pos = '0;
    cur_neg = '0;
    cur_cnt = '0;
    for (int s = 0; s < SN; s++) begin
      if (stg_q == SW'(s)) begin
        cur_msk = cfg_msk[s*DW +: DW];
        cur_val = cfg_val[s*DW +: DW];
        cur_pos = cfg_pos[s*DW +: DW];
        cur_neg = cfg_neg[s*DW +: DW];
        cur_cnt = cfg_cnt[s*CW +: CW];
      end
    end

    pos = pvl_q ? (~prv_q & sti_tdata) : '0;
    neg = pvl_q ? (prv_q & ~sti_tdata) : '0;
    cmp = ((sti_tdata ^ cur_val) & cur_msk) == '0;
    edg = ((cur_pos | cur_neg) == '0) ? 1'b1 : |((pos & cur_pos) | (neg & cur_neg));
    hit = cmp & edg;

    // Out-of-range configuration is clamped so a live reconfiguration can never strand the sequencer.
    if (cfg_num == '0) begin
      num_eff = NW'(1);
    end else if (cfg_num > NW'(SN)) begin
      num_eff = NW'(SN);
    end else begin
      num_eff = cfg_num;
    end
    at_last = NW'(stg_q) >= (num_eff - NW'(1));

    need    = (cur_cnt == '0) ? (CW+1)'(1) : {1'b0, cur_cnt};
    cnt_d   = {1'b0, cnt_q} + (CW+1)'(1);
    reached = cnt_d >= need;
    stg_d   = stg_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      stg_q   <= '0;
      cnt_q   <= '0;
      prv_q   <= '0;
      pvl_q   <= 1'b0;
      trg_q   <= 1'b0;
      arm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (ctl_rst) begin
      state_q <= IDLE;
      stg_q   <= '0;
      cnt_q   <= '0;
      prv_q   <= '0;
      pvl_q   <= 1'b0;
      trg_q   <= 1'b0;
      arm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      trg_q <= 1'b0;
      if (xfer) begin
        prv_q <= sti_tdata;
        pvl_q <= 1'b1;
      end
      // Arming wins over evaluation: a transfer in the arming cycle only updates edge history.
      if (ctl_arm) begin
        state_q <= ARMED;
        arm_q   <= 1'b1;
        done_q  <= 1'b0;
        stg_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == ARMED && xfer && hit) begin
        if (reached) begin
          cnt_q <= '0;
          if (at_last) begin
            state_q <= DONE;
            arm_q   <= 1'b0;
            done_q  <= 1'b1;
            trg_q   <= 1'b1;
          end else begin
            stg_q <= stg_d;
          end
        end else begin
          cnt_q <= cnt_d[CW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_la_trg_seq.sv
// Bench for la_trg_seq: a behavioural sequencer model checked every cycle, plus directed
// scenarios with hand-computed trigger beats and status values.
module tb_la_trg_seq;

  localparam int DW = 8;
  localparam int SN = 4;
  localparam int CW = 16;
  localparam int NW = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          ctlRst;
  logic          ctlArm;
  logic [NW-1:0] cfgNum;
  logic [DW-1:0] cfgMsk [SN];
  logic [DW-1:0] cfgVal [SN];
  logic [DW-1:0] cfgPos [SN];
  logic [DW-1:0] cfgNeg [SN];
  logic [CW-1:0] cfgCnt [SN];
  logic [SN*DW-1:0] mskFlat, valFlat, posFlat, negFlat;
  logic [SN*CW-1:0] cntFlat;
  logic          stsArm, stsTrg, stsDone;
  logic [SW-1:0] stsStg;
  logic [DW-1:0] stiTdata, stoTdata;
  logic          stiTlast, stiTvalid, stiTready;
  logic          stoTlast, stoTvalid, stoTready;

  int errors = 0;
  int checks = 0;

  always_comb begin
    mskFlat = '0;
    valFlat = '0;
    posFlat = '0;
    negFlat = '0;
    cntFlat = '0;
    for (int s = 0; s < SN; s++) begin
      mskFlat[s*DW +: DW] = cfgMsk[s];
      valFlat[s*DW +: DW] = cfgVal[s];
      posFlat[s*DW +: DW] = cfgPos[s];
      negFlat[s*DW +: DW] = cfgNeg[s];
      cntFlat[s*CW +: CW] = cfgCnt[s];
    end
  end

  la_trg_seq #(.DW(DW), .SN(SN), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .ctl_rst(ctlRst), .ctl_arm(ctlArm),
    .cfg_num(cfgNum), .cfg_msk(mskFlat), .cfg_val(valFlat),
    .cfg_pos(posFlat), .cfg_neg(negFlat), .cfg_cnt(cntFlat),
    .sts_arm(stsArm), .sts_stg(stsStg), .sts_trg(stsTrg), .sts_done(stsDone),
    .sti_tdata(stiTdata), .sti_tlast(stiTlast), .sti_tvalid(stiTvalid), .sti_tready(stiTready),
    .sto_tdata(stoTdata), .sto_tlast(stoTlast), .sto_tvalid(stoTvalid), .sto_tready(stoTready)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 armed, 2 done
  typedef struct packed {
    int          phase;
    int          stage;
    longint      count;
    logic [7:0]  prv;
    bit          pvl;
    bit          trg;
  } ModelT;

  ModelT mdl;

  function automatic ModelT modelReset();
    ModelT r;
    r.phase = 0; r.stage = 0; r.count = 0; r.prv = '0; r.pvl = 0; r.trg = 0;
    return r;
  endfunction

  function automatic bit stageHit(int s, logic [7:0] d, logic [7:0] p, bit pv);
    bit anyEdge = 0;
    bit edgeSeen = 0;
    for (int b = 0; b < DW; b++) begin
      if (cfgMsk[s][b] && (d[b] != cfgVal[s][b])) return 0;
      if (cfgPos[s][b] || cfgNeg[s][b]) anyEdge = 1;
      if (pv && cfgPos[s][b] && !p[b] && d[b]) edgeSeen = 1;
      if (pv && cfgNeg[s][b] && p[b] && !d[b]) edgeSeen = 1;
    end
    return !anyEdge || edgeSeen;
  endfunction

  function automatic ModelT modelNext(ModelT c);
    ModelT  n;
    int     active;
    longint need;
    bit     xfer;
    n = c;
    n.trg = 0;
    xfer = stiTvalid && stoTready;
    if (ctlRst) return modelReset();
    if (xfer) begin
      n.prv = stiTdata;
      n.pvl = 1;
    end
    if (ctlArm) begin
      n.phase = 1; n.stage = 0; n.count = 0;
      return n;
    end
    if (c.phase == 1 && xfer && stageHit(c.stage, stiTdata, c.prv, c.pvl)) begin
      active = (cfgNum == 0) ? 1 : ((int'(cfgNum) > SN) ? SN : int'(cfgNum));
      need = (cfgCnt[c.stage] == 0) ? 1 : longint'(cfgCnt[c.stage]);
      n.count = c.count + 1;
      if (n.count >= need) begin
        n.count = 0;
        if (c.stage + 1 >= active) begin
          n.phase = 2;
          n.trg = 1;
        end else begin
          n.stage = c.stage + 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) mdl <= modelReset();
    else       mdl <= modelNext(mdl);
  end

  always @(negedge clk) begin
    checkOutput("mdlArm",  64'(stsArm),  64'(mdl.phase == 1));
    checkOutput("mdlDone", 64'(stsDone), 64'(mdl.phase == 2));
    checkOutput("mdlTrg",  64'(stsTrg),  64'(mdl.trg));
    checkOutput("mdlStg",  64'(stsStg),  64'(mdl.stage));
    checkOutput("passData",  64'(stoTdata),  64'(stiTdata));
    checkOutput("passLast",  64'(stoTlast),  64'(stiTlast));
    checkOutput("passValid", 64'(stoTvalid), 64'(stiTvalid));
    checkOutput("passReady", 64'(stiTready), 64'(stoTready));
  end

  task automatic applyStimulus(input logic [7:0] data, input logic valid, input logic ready,
                               input logic rst, input logic arm);
    stiTdata  = data;
    stiTlast  = data[0];
    stiTvalid = valid;
    stoTready = ready;
    ctlRst    = rst;
    ctlArm    = arm;
    @(posedge clk);
    #1;
    ctlRst    = 1'b0;
    ctlArm    = 1'b0;
    stiTvalid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] data);
    applyStimulus(data, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic armPulse();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic softReset();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic setStage(input int s, input logic [7:0] msk, input logic [7:0] val,
                          input logic [7:0] pos, input logic [7:0] neg, input logic [CW-1:0] cnt);
    cfgMsk[s] = msk; cfgVal[s] = val; cfgPos[s] = pos; cfgNeg[s] = neg; cfgCnt[s] = cnt;
  endtask

  task automatic clearCfg();
    for (int s = 0; s < SN; s++) setStage(s, 8'h00, 8'h00, 8'h00, 8'h00, 16'd1);
    cfgNum = 3'd1;
  endtask

  task automatic cfgThree();
    clearCfg();
    setStage(0, 8'hFF, 8'h03, 8'h00, 8'h00, 16'd1);
    setStage(1, 8'h00, 8'h00, 8'h01, 8'h00, 16'd1);
    setStage(2, 8'hFF, 8'h0A, 8'h00, 8'h00, 16'd2);
    cfgNum = 3'd3;
  endtask

  logic [7:0] seq3 [6] = '{8'h03, 8'h04, 8'h05, 8'h0A, 8'h0B, 8'h0A};
  int         stg3 [6] = '{1, 1, 2, 2, 2, 2};

  // Plays the three-stage stream and checks the hand-derived stage walk and trigger beat.
  task automatic runThree(input string tag);
    for (int i = 0; i < 6; i++) begin
      beat(seq3[i]);
      checkOutput({tag, "Stg"}, 64'(stsStg), 64'(stg3[i]));
      checkOutput({tag, "Trg"}, 64'(stsTrg), 64'(i == 5));
    end
    checkOutput({tag, "Done"}, 64'(stsDone), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int guard;
    int trgBeat;
    rstn = 1'b0;
    ctlRst = 1'b0; ctlArm = 1'b0;
    stiTdata = '0; stiTlast = 1'b0; stiTvalid = 1'b0; stoTready = 1'b1;
    clearCfg();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    checkOutput("rstArm",  64'(stsArm),  64'd0);
    checkOutput("rstStg",  64'(stsStg),  64'd0);
    checkOutput("rstTrg",  64'(stsTrg),  64'd0);
    checkOutput("rstDone", 64'(stsDone), 64'd0);

    $display("[TB] single stage, value 08");
    setStage(0, 8'hFF, 8'h08, 8'h00, 8'h00, 16'd1);
    armPulse();
    checkOutput("t1Arm", 64'(stsArm), 64'd1);
    for (int i = 0; i <= 16; i++) begin
      beat(8'(i));
      checkOutput("t1Trg",  64'(stsTrg),  64'(i == 8));
      checkOutput("t1Done", 64'(stsDone), 64'(i >= 8));
    end

    $display("[TB] three-stage sequence");
    softReset();
    cfgThree();
    armPulse();
    runThree("t2");

    $display("[TB] backpressure");
    softReset();
    armPulse();
    idx = 0; guard = 0; trgBeat = -1;
    while (idx < 6 && guard < 200) begin
      guard++;
      case ($urandom_range(0, 3))
        0: begin
          applyStimulus(seq3[idx], 1'b1, 1'b0, 1'b0, 1'b0);
          checkOutput("bpStallTrg", 64'(stsTrg), 64'd0);
        end
        1: begin
          applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
          checkOutput("bpIdleTrg", 64'(stsTrg), 64'd0);
        end
        default: begin
          beat(seq3[idx]);
          if (stsTrg) trgBeat = idx;
          checkOutput("bpStg", 64'(stsStg), 64'(stg3[idx]));
          idx++;
        end
      endcase
    end
    checkOutput("bpBeats", 64'(idx), 64'd6);
    checkOutput("bpTrgBeat", 64'(trgBeat), 64'd5);

    $display("[TB] edge history after soft reset");
    softReset();
    clearCfg();
    setStage(0, 8'h00, 8'h00, 8'h01, 8'h00, 16'd1);
    armPulse();
    beat(8'hFF);
    checkOutput("edgFirst", 64'(stsTrg), 64'd0);
    beat(8'hFE);
    checkOutput("edgFall", 64'(stsTrg), 64'd0);
    beat(8'hFF);
    checkOutput("edgRise", 64'(stsTrg), 64'd1);

    $display("[TB] arm with transfer in idle, cfg_num=0 and cnt=0");
    softReset();
    clearCfg();
    setStage(0, 8'hFF, 8'h08, 8'h00, 8'h00, 16'd0);
    cfgNum = 3'd0;
    applyStimulus(8'h08, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("armXferArm", 64'(stsArm), 64'd1);
    checkOutput("armXferTrg", 64'(stsTrg), 64'd0);
    beat(8'h08);
    checkOutput("cnt0Trg", 64'(stsTrg), 64'd1);

    $display("[TB] cfg_num above SN clamps to SN");
    softReset();
    clearCfg();
    for (int s = 0; s < SN; s++) setStage(s, 8'hFF, 8'(s + 1), 8'h00, 8'h00, 16'd1);
    cfgNum = 3'd7;
    armPulse();
    for (int i = 1; i <= 4; i++) begin
      beat(8'(i));
      checkOutput("clampTrg", 64'(stsTrg), 64'(i == 4));
      if (i < 4) checkOutput("clampStg", 64'(stsStg), 64'(i));
    end

    $display("[TB] restart, soft reset mid-sequence, re-arm from done");
    softReset();
    cfgThree();
    armPulse();
    beat(8'h03);
    checkOutput("srStg1", 64'(stsStg), 64'd1);
    armPulse();
    checkOutput("restartStg", 64'(stsStg), 64'd0);
    checkOutput("restartArm", 64'(stsArm), 64'd1);
    beat(8'h03);
    beat(8'h02);
    checkOutput("srHold", 64'(stsStg), 64'd1);
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("srArm",  64'(stsArm),  64'd0);
    checkOutput("srStg",  64'(stsStg),  64'd0);
    checkOutput("srTrg",  64'(stsTrg),  64'd0);
    checkOutput("srDone", 64'(stsDone), 64'd0);
    armPulse();
    runThree("sr1");
    armPulse();
    checkOutput("rearmArm",  64'(stsArm),  64'd1);
    checkOutput("rearmDone", 64'(stsDone), 64'd0);
    runThree("sr2");

    $display("[TB] async reset mid-sequence");
    softReset();
    armPulse();
    beat(8'h03);
    checkOutput("arPre", 64'(stsStg), 64'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("arArm",  64'(stsArm),  64'd0);
    checkOutput("arStg",  64'(stsStg),  64'd0);
    checkOutput("arTrg",  64'(stsTrg),  64'd0);
    checkOutput("arDone", 64'(stsDone), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
